// File: rtl/rifl_vcode_pkg.sv
// Shared constants and the bit-serial CRC beat step used by the TX code generator, the RX checker and models.
// The step is width-generic up to MAX_DWIDTH/MAX_CRC_WIDTH so one function serves every configuration.
package rifl_vcode_pkg;
    localparam logic [1:0]  DATA_HDR      = 2'b01;
    localparam int          DEF_CRC_WIDTH = 12;
    localparam logic [11:0] DEF_CRC_POLY  = 12'h02f;
    localparam int          MAX_CRC_WIDTH = 32;
    localparam int          MAX_DWIDTH    = 256;

    // Operands are left-aligned so the MSB-first loop only ever touches constant bit positions.
    function automatic logic [MAX_CRC_WIDTH-1:0] crc_step_beat(
        input logic [MAX_CRC_WIDTH-1:0] crc,
        input logic [MAX_DWIDTH-1:0]    beat,
        input int                       dw   = 64,
        input int                       cw   = DEF_CRC_WIDTH,
        input logic [MAX_CRC_WIDTH-1:0] poly = MAX_CRC_WIDTH'(DEF_CRC_POLY)
    );
        logic [MAX_CRC_WIDTH-1:0] c;
        logic [MAX_CRC_WIDTH-1:0] p;
        logic [MAX_DWIDTH-1:0]    b;
        logic                     fb;
        c  = crc << (MAX_CRC_WIDTH - cw);
        p  = (poly | MAX_CRC_WIDTH'(1)) << (MAX_CRC_WIDTH - cw);
        b  = beat << (MAX_DWIDTH - dw);
        fb = 1'b0;
        for (int i = 0; i < MAX_DWIDTH; i++) begin
            if (i < dw) begin
                fb = c[MAX_CRC_WIDTH-1] ^ b[MAX_DWIDTH-1];
                c  = c << 1;
                if (fb) c = c ^ p;
                b  = b << 1;
            end
        end
        return c >> (MAX_CRC_WIDTH - cw);
    endfunction
endpackage

// File: rtl/vcode_crc_acc.sv
// Registered per-frame CRC accumulator; crc_next is the combinational step over the current beat.
// restart seeds the step from zero instead of the stored value; clr has priority over en.
module vcode_crc_acc
    import rifl_vcode_pkg::*;
#(
    parameter int                   DWIDTH    = 64,
    parameter int                   CRC_WIDTH = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 12'h02f
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 restart,
    input  logic [DWIDTH-1:0]    beat,
    output logic [CRC_WIDTH-1:0] crc_next
);
    logic [CRC_WIDTH-1:0]     crc;
    logic [MAX_CRC_WIDTH-1:0] base;

    assign base     = restart ? '0 : MAX_CRC_WIDTH'(crc);
    assign crc_next = CRC_WIDTH'(crc_step_beat(base, MAX_DWIDTH'(beat), DWIDTH, CRC_WIDTH,
                                               MAX_CRC_WIDTH'(CRC_POLY)));

    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= '0;
        else if (en)
            crc <= crc_next;
    end
endmodule

// File: rtl/vcode_check.sv
// RX verification-code checker: recomputes the frame CRC, XORs the expected frame ID and compares with the tail code.
// Every beat is re-emitted one cycle later with ok/err/trunc pulses aligned to it; no backpressure.
module vcode_check
    import rifl_vcode_pkg::*;
#(
    parameter int                   FRAME_WIDTH    = 256,
    parameter int                   DWIDTH         = 64,
    parameter int                   CRC_WIDTH      = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
    parameter int                   FRAME_ID_WIDTH = 8,
    parameter int                   ERR_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      sof,
    input  logic [DWIDTH-1:0]         data_in,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic [DWIDTH-1:0]         data_out,
    output logic                      frame_ok,
    output logic                      frame_err,
    output logic                      frame_trunc,
    output logic [FRAME_ID_WIDTH-1:0] expected_id,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);
    localparam int N     = FRAME_WIDTH / DWIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     beat_idx;
    logic                 is_data_q;
    logic                 beat_sof;
    logic                 active;
    logic                 is_tail;
    logic                 frame_is_data;
    logic                 restart;
    logic                 trunc;
    logic                 pass;
    logic                 fail;
    logic [DWIDTH-1:0]    chk_beat;
    logic [CRC_WIDTH-1:0] crc_next;
    logic [CRC_WIDTH-1:0] calc;

    // cnt == 0 means idle; otherwise it is the index of the next beat expected in the frame.
    always_comb begin
        beat_sof      = in_valid & sof;
        active        = beat_sof | (in_valid & (cnt != '0));
        beat_idx      = beat_sof ? '0 : cnt;
        is_tail       = active & (beat_idx == LAST);
        frame_is_data = beat_sof ? (data_in[DWIDTH-1 -: 2] == DATA_HDR) : is_data_q;
        restart       = beat_sof | (is_tail & ~frame_is_data);
        trunc         = beat_sof & (cnt != '0);
        chk_beat      = data_in;
        if (is_tail)
            chk_beat[CRC_WIDTH-1:0] = '0;
        calc          = crc_next ^ CRC_WIDTH'(expected_id);
        pass          = (calc == data_in[CRC_WIDTH-1:0]);
        fail          = is_tail & ~pass;
    end

    // Control frames accumulate junk on their body beats; restart at the tail discards it.
    vcode_crc_acc #(
        .DWIDTH    (DWIDTH),
        .CRC_WIDTH (CRC_WIDTH),
        .CRC_POLY  (CRC_POLY)
    ) u_crc (
        .clk      (clk),
        .rst      (rst),
        .clr      (is_tail),
        .en       (active),
        .restart  (restart),
        .beat     (chk_beat),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            is_data_q <= 1'b0;
        end else begin
            if (is_tail)
                cnt <= '0;
            else if (beat_sof)
                cnt <= CNT_W'(1);
            else if (active)
                cnt <= cnt + CNT_W'(1);
            if (beat_sof)
                is_data_q <= frame_is_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            data_out    <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            frame_trunc <= 1'b0;
            expected_id <= '0;
            err_cnt     <= '0;
        end else begin
            out_valid   <= in_valid;
            out_sof     <= beat_sof;
            data_out    <= chk_beat;
            frame_ok    <= is_tail & pass;
            frame_err   <= fail;
            frame_trunc <= trunc;
            if (is_tail && pass && frame_is_data)
                expected_id <= expected_id + FRAME_ID_WIDTH'(1);
            if ((trunc || fail) && (err_cnt != '1))
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end
endmodule
